qtz_seg_loader: RTL

Parametrised segment loader for the quantizer output path: accepts fixed-width segments of quantized feature values over a valid/ready handshake and steps a segment counter. For each accepted segment it drives a one-hot register enable and writes the segment into the per-feature level register bank. The final segment may be partial. The block replaces the fixed 10-way select-to-enable decode and adds sequencing, back-pressure, abort and frame-complete signalling.

---
 rtl/qtz_seg_pkg.sv | 23 ++
 rtl/seg_onehot_dec.sv | 20 ++
 rtl/qtz_seg_loader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/qtz_seg_pkg.sv
// rtl/qtz_seg_pkg.sv - shared state type, default sizes and sizing helpers for qtz_seg_loader
package qtz_seg_pkg;

    localparam int QTZ_FEATURE_COUNT = 617;
    localparam int QTZ_SEG_LEN       = 62;
    localparam int QTZ_ELEM_W        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } qtz_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // A single-segment frame still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_onehot_dec.sv
// rtl/seg_onehot_dec.sv - index-to-one-hot decoder with enable; out-of-range index decodes to zero
module seg_onehot_dec #(
    parameter int N     = 10,
    parameter int IDX_W = 4
) (
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (idx == IDX_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qtz_seg_loader.sv
// rtl/qtz_seg_loader.sv - segment sequencer and one-hot strobe generator for the quantizer output path
// Optional per-feature level bank and level_out port under QTZ_SEG_BUF_EN.
module qtz_seg_loader
    import qtz_seg_pkg::*;
#(
    parameter int  FEATURE_COUNT = QTZ_FEATURE_COUNT,
    parameter int  SEG_LEN       = QTZ_SEG_LEN,
    parameter int  ELEM_W        = QTZ_ELEM_W,
    localparam int NUM_SEG       = ceil_div(FEATURE_COUNT, SEG_LEN),
    localparam int IDX_W         = idx_width(NUM_SEG)
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        seg_valid,
    output logic                        seg_ready,
    input  logic [SEG_LEN*ELEM_W-1:0]   seg_data,
    output logic [IDX_W-1:0]            seg_idx,
    output logic [NUM_SEG-1:0]          qtz_out_reg_en,
    output logic                        busy,
    output logic                        done
`ifdef QTZ_SEG_BUF_EN
    ,
    output logic [FEATURE_COUNT*ELEM_W-1:0] level_out
`endif
);

    qtz_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             accept;
    logic             last_seg;

    assign last_seg = (idx_q == IDX_W'(NUM_SEG - 1));
    assign seg_idx  = idx_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // seg_ready is a function of state and abort only, never of seg_valid.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seg_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                seg_ready = !abort;
                accept    = seg_valid && !abort;
                if (accept) begin
                    if (last_seg) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? LOAD : IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    seg_onehot_dec #(
        .N     (NUM_SEG),
        .IDX_W (IDX_W)
    ) u_dec (
        .en     (accept),
        .idx    (idx_q),
        .onehot (qtz_out_reg_en)
    );

    // Tail-segment elements beyond the last feature and the whole bus without a bank go nowhere.
    logic unused_seg_data;
    assign unused_seg_data = ^seg_data;

`ifdef QTZ_SEG_BUF_EN
    logic [ELEM_W-1:0] bank_q [FEATURE_COUNT];

    // Feature f belongs to segment f/SEG_LEN at element f%SEG_LEN; the tail is clipped by construction.
    for (genvar f = 0; f < FEATURE_COUNT; f++) begin : g_feat
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                bank_q[f] <= '0;
            end else if (qtz_out_reg_en[f / SEG_LEN]) begin
                bank_q[f] <= seg_data[(f % SEG_LEN)*ELEM_W +: ELEM_W];
            end
        end
        assign level_out[f*ELEM_W +: ELEM_W] = bank_q[f];
    end
`endif

endmodule
